glyph_row_packer: RTL and testbench

- Inverse of the text-mode pixel colouriser: takes a raster stream of 12-bit pixel colours for one 8x8 character cell and packs it back into eight 8-bit glyph rows.
- A pixel matching the foreground key becomes a 1 bit; any other colour becomes a 0 bit.
- Sits between the bitmap/font import path and the font RAM write port.
- Lets software or a capture unit define custom glyphs as colour pixels.

---
 rtl/glyph_row_packer_pkg.sv | 17 +
 rtl/glyph_row_packer_bit_shifter.sv | 36 +++
 rtl/glyph_row_packer.sv | 124 ++++++++++++
 tb/tb_glyph_row_packer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_row_packer_pkg.sv
// Shared video definitions for the glyph import path: FSM states,
// glyph geometry and the RGB444 colour width used by the renderer.
package glyph_row_packer_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;
    localparam int COLOR_W = 12;
    localparam int BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } packer_state_e;

endpackage

// File: rtl/glyph_row_packer_bit_shifter.sv
// Accumulates one glyph row: MSB-first shift register, pixel counter and
// a byte-complete strobe that fires on the eighth enabled shift.
module glyph_bit_shifter
    import glyph_row_packer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic               bit_i,
    output logic [GLYPH_W-1:0] byte_o,
    output logic               complete_o
);

    logic [GLYPH_W-1:0]   shift_q;
    logic [BIT_CNT_W-1:0] bit_q;
    logic                 last_bit;

    assign last_bit   = (bit_q == BIT_CNT_W'(GLYPH_W - 1));
    assign byte_o     = {shift_q[GLYPH_W-2:0], bit_i};
    assign complete_o = en_i && last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_q   <= '0;
        end else if (clr_i) begin
            shift_q <= '0;
            bit_q   <= '0;
        end else if (en_i) begin
            shift_q <= byte_o;
            bit_q   <= last_bit ? '0 : bit_q + BIT_CNT_W'(1);
        end
    end

endmodule

// File: rtl/glyph_row_packer.sv
// Packs an 8x8 cell of RGB444 pixels into eight glyph rows by matching each
// pixel against a latched foreground key, then writes them to font RAM.
module glyph_row_packer
    import glyph_row_packer_pkg::*;
#(
    parameter int CODE_W = 8,
    parameter int ROWS   = GLYPH_H
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CODE_W-1:0]   char_code,
    input  logic [COLOR_W-1:0]  fcol,
    input  logic                abort,
    input  logic                pix_valid,
    input  logic [COLOR_W-1:0]  pix_color,
    output logic                pix_ready,
    output logic                wr_en,
    output logic [CODE_W+2:0]   wr_addr,
    output logic [GLYPH_W-1:0]  wr_data,
    input  logic                wr_ready,
    output logic                busy,
    output logic                done
);

    packer_state_e      state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [COLOR_W-1:0] fcol_q, fcol_d;
    logic [2:0]         row_q, row_d;
    logic [CODE_W+2:0]  addr_q, addr_d;
    logic [GLYPH_W-1:0] data_q, data_d;

    logic               sh_clr;
    logic               sh_en;
    logic               sh_complete;
    logic [GLYPH_W-1:0] sh_byte;

    assign pix_ready = (state_q == ST_COLLECT);
    assign wr_en     = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;

    // Abort blocks the shift so a cancelled row never reaches the write port.
    assign sh_en = pix_valid && pix_ready && !abort;

    glyph_bit_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (sh_clr),
        .en_i       (sh_en),
        .bit_i      (pix_color == fcol_q),
        .byte_o     (sh_byte),
        .complete_o (sh_complete)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        fcol_d  = fcol_q;
        row_d   = row_q;
        addr_d  = addr_q;
        data_d  = data_q;
        sh_clr  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    code_d  = char_code;
                    fcol_d  = fcol;
                    row_d   = '0;
                    sh_clr  = 1'b1;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sh_complete) begin
                    data_d  = sh_byte;
                    addr_d  = {code_q, row_q};
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wr_ready) begin
                    if (row_q == 3'(ROWS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d   = row_q + 3'd1;
                        sh_clr  = 1'b1;
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            fcol_q  <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            fcol_q  <= fcol_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_glyph_row_packer.sv
// Directed and randomized bench for glyph_row_packer, checked against a
// pixel-array reference model of the expected font RAM writes.
module tb_glyph_row_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  char_code;
    logic [11:0] fcol;
    logic        abort;
    logic        pix_valid;
    logic [11:0] pix_color;
    logic        pix_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;

    logic [11:0] pix [64];
    wr_t got[$];
    wr_t exp_q[$];
    int  first_t;
    int  done_t;

    glyph_row_packer #(.CODE_W(8), .ROWS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .char_code (char_code),
        .fcol      (fcol),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_color (pix_color),
        .pix_ready (pix_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Runs one glyph: drives pixels from pix[], optional 1/0 valid gaps,
    // optional wr_ready stall on row 3, optional abort after abort_pix pixels.
    task automatic pack(input logic [7:0] code, input logic [11:0] key, input bit gap,
                        input int bp_cyc, input int abort_pix, input string name);
        int  consumed = 0;
        int  dones = 0;
        int  bp_left = bp_cyc;
        int  post = 0;
        int  nrows;
        bit  stall;
        bit  aborted = 0;
        bit  fin = 0;
        logic [7:0] b;
        got.delete();
        exp_q.delete();
        first_t = -1;
        done_t  = -1;
        nrows = (abort_pix >= 0) ? abort_pix / 8 : 8;
        for (int r = 0; r < nrows; r++) begin
            b = '0;
            for (int c = 0; c < 8; c++) b[7-c] = (pix[r*8+c] == key);
            exp_q.push_back({code, 3'(r), b});
        end

        @(posedge clk); #1;
        start = 1'b1; char_code = code; fcol = key;
        @(negedge clk);

        for (int t = 0; t < 2000 && !fin; t++) begin
            @(posedge clk); #1;
            start     = (t == 3);
            char_code = 8'($urandom);
            fcol      = 12'($urandom);
            abort     = 1'b0;
            pix_valid = 1'b0;
            if (!aborted && abort_pix >= 0 && consumed == abort_pix) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end else if (!aborted && consumed < 64) begin
                pix_valid = gap ? (t % 2 == 0) : 1'b1;
            end
            pix_color = pix_valid ? pix[consumed] : 12'($urandom);
            stall = 1'b0;
            if (wr_en && got.size() == 3 && bp_left > 0) begin
                wr_ready = 1'b0;
                bp_left--;
                stall = 1'b1;
            end else begin
                wr_ready = wr_en ? 1'b1 : 1'($urandom);
            end

            @(negedge clk);
            if (stall && exp_q.size() > 3) begin
                chk({name, "_stall_wr_en"}, wr_en, 1);
                chk({name, "_stall_addr"}, wr_addr, exp_q[3].a);
                chk({name, "_stall_data"}, wr_data, exp_q[3].d);
                chk({name, "_stall_pix_ready"}, pix_ready, 0);
            end
            if (pix_valid && pix_ready) begin
                if (first_t < 0) first_t = t;
                consumed++;
            end
            if (wr_en && wr_ready) got.push_back({wr_addr, wr_data});
            if (done) begin
                dones++;
                done_t = t;
            end
            if (aborted) post++;
            if (post == 2) begin
                chk({name, "_abort_busy"}, busy, 0);
                chk({name, "_abort_wr_en"}, wr_en, 0);
            end
            if (dones > 0 || post >= 12) fin = 1'b1;
        end
        chk({name, "_no_timeout"}, fin, 1);

        @(posedge clk); #1;
        start = 1'b0; pix_valid = 1'b0; abort = 1'b0; wr_ready = 1'b1;
        @(negedge clk);
        chk({name, "_done_one_cycle"}, done, 0);
        chk({name, "_busy_after"}, busy, 0);

        chk({name, "_done_count"}, dones, (abort_pix >= 0) ? 0 : 1);
        chk({name, "_write_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({name, "_wr_addr"}, got[i].a, exp_q[i].a);
            chk({name, "_wr_data"}, got[i].d, exp_q[i].d);
        end
        if (!gap && bp_cyc == 0 && abort_pix < 0)
            chk({name, "_latency"}, done_t - first_t, 72);
    endtask

    task automatic fill_random(input logic [11:0] key);
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 2))
                0:       pix[i] = key;
                1:       pix[i] = key ^ (12'd1 << $urandom_range(0, 11));
                default: pix[i] = 12'($urandom);
            endcase
        end
    endtask

    initial begin
        logic [11:0] key;
        bit seen;
        rst_n = 1'b0; start = 1'b0; char_code = '0; fcol = '0; abort = 1'b0;
        pix_valid = 1'b0; pix_color = '0; wr_ready = 1'b0;
        #2;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Checkerboard, phase alternating per row.
        for (int i = 0; i < 64; i++) pix[i] = (((i / 8) + (i % 8)) % 2 == 0) ? 12'hFFF : 12'h000;
        pack(8'h41, 12'hFFF, 1'b0, 0, -1, "checker");
        if (got.size() == 8) begin
            chk("checker_row0_addr", got[0].a, 11'h208);
            chk("checker_row0_data", got[0].d, 8'hAA);
            chk("checker_row7_addr", got[7].a, 11'h20F);
            chk("checker_row7_data", got[7].d, 8'h55);
        end

        for (int i = 0; i < 64; i++) pix[i] = 12'hF01;
        pack(8'h10, 12'hF00, 1'b0, 0, -1, "near_miss");
        if (got.size() > 0) chk("near_miss_byte", got[0].d, 8'h00);
        for (int i = 0; i < 64; i++) pix[i] = 12'hF00;
        pack(8'h11, 12'hF00, 1'b0, 0, -1, "exact");
        if (got.size() > 0) chk("exact_byte", got[0].d, 8'hFF);

        key = 12'($urandom); fill_random(key);
        pack(8'($urandom), key, 1'b0, 5, -1, "backpressure");
        pack(8'($urandom), key, 1'b1, 0, -1, "gapped");

        key = 12'($urandom); fill_random(key);
        pack(8'h43, key, 1'b0, 0, 27, "abort");
        key = 12'($urandom); fill_random(key);
        pack(8'h42, key, 1'b0, 0, -1, "after_abort");

        // Asynchronous reset while a row write is stalled.
        @(posedge clk); #1;
        start = 1'b1; char_code = 8'h55; fcol = 12'h123;
        @(posedge clk); #1;
        start = 1'b0; wr_ready = 1'b0; pix_valid = 1'b1; pix_color = 12'h123;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = wr_en;
        end
        chk("rst_mid_reached_write", seen, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", wr_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        key = 12'($urandom); fill_random(key);
        pack(8'hC3, key, 1'b0, 0, -1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
